// File: rtl/pc_halt_dump_monitor.sv
// End-of-program monitor: detects the halt PC (or a watchdog expiry), waits for the
// pipeline to drain, then streams a window of data memory one word per cycle.
module pc_halt_dump_monitor #(
    parameter int              PC_W           = 32,
    parameter int              DATA_W         = 32,
    parameter int              MEM_AW         = 10,
    parameter logic [PC_W-1:0] END_PC         = PC_W'(32'h90),
    parameter int              DUMP_BASE      = 32,
    parameter int              DUMP_WORDS     = 96,
    parameter int              WORDS_PER_LINE = 16,
    parameter int              DRAIN_CYCLES   = 4,
    parameter int              TIMEOUT_CYCLES = 100000,
    parameter int              CNT_W          = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [PC_W-1:0]   PC,
    input  logic              PC_VALID,
    output logic [MEM_AW-1:0] dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              halt_req,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [MEM_AW-1:0] dump_idx,
    output logic              dump_eol,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int KW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam int LW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [KW-1:0]     K_LAST   = KW'(DUMP_WORDS - 1);
    localparam logic [LW-1:0]     L_LAST   = LW'(WORDS_PER_LINE - 1);
    localparam logic [DW-1:0]     D_LAST   = DW'(DRAIN_CYCLES - 1);
    localparam logic [MEM_AW-1:0] BASE_A   = MEM_AW'(DUMP_BASE);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam bit                NO_DRAIN = (DRAIN_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cycle_count_q;
    logic [DW-1:0]       drain_q;
    logic [KW-1:0]       k_q;
    logic [LW-1:0]       line_q;
    logic [MEM_AW-1:0]   dm_raddr_q;
    logic [MEM_AW-1:0]   dump_idx_q;
    logic                halt_req_q;
    logic                dump_valid_q;
    logic                dump_eol_q;
    logic                done_q;
    logic                timed_out_q;

    logic                match_s;
    logic                timeout_s;
    logic                eol_s;

    // Halt detection (match beats watchdog) and end-of-line flag for the word being addressed.
    always_comb begin
        match_s   = 1'b0;
        timeout_s = 1'b0;
        eol_s     = 1'b0;
        if (state_q == ST_RUN) begin
            match_s   = PC_VALID && (PC == END_PC);
            timeout_s = TO_EN && (cycle_count_q == TO_LAST) && !match_s;
        end else begin
            match_s   = 1'b0;
            timeout_s = 1'b0;
        end
        eol_s = (line_q == L_LAST) || (k_q == K_LAST);
    end

    // Monitor FSM with all outputs registered.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q       <= ST_RUN;
            cycle_count_q <= {CNT_W{1'b0}};
            drain_q       <= {DW{1'b0}};
            k_q           <= {KW{1'b0}};
            line_q        <= {LW{1'b0}};
            dm_raddr_q    <= {MEM_AW{1'b0}};
            dump_idx_q    <= {MEM_AW{1'b0}};
            halt_req_q    <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_eol_q    <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cycle_count_q != {CNT_W{1'b1}}) begin
                        cycle_count_q <= cycle_count_q + 1'b1;
                    end
                    if (match_s || timeout_s) begin
                        halt_req_q  <= 1'b1;
                        timed_out_q <= timeout_s;
                        drain_q     <= {DW{1'b0}};
                        if (NO_DRAIN) begin
                            state_q    <= ST_DUMP;
                            dm_raddr_q <= BASE_A;
                            k_q        <= {KW{1'b0}};
                            line_q     <= {LW{1'b0}};
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == D_LAST) begin
                        state_q    <= ST_DUMP;
                        dm_raddr_q <= BASE_A;
                        k_q        <= {KW{1'b0}};
                        line_q     <= {LW{1'b0}};
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                ST_DUMP: begin
                    // Memory answers the current address next cycle, so tag it now.
                    dump_valid_q <= 1'b1;
                    dump_idx_q   <= dm_raddr_q;
                    dump_eol_q   <= eol_s;
                    line_q       <= (line_q == L_LAST) ? {LW{1'b0}} : line_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q        <= k_q + 1'b1;
                        dm_raddr_q <= dm_raddr_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    dump_valid_q <= 1'b0;
                    dump_eol_q   <= 1'b0;
                    done_q       <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Read data arrives from the memory's own output register, aligned with dump_valid.
    assign dump_data   = dump_valid_q ? dm_rdata : {DATA_W{1'b0}};
    assign dm_raddr    = dm_raddr_q;
    assign halt_req    = halt_req_q;
    assign dump_valid  = dump_valid_q;
    assign dump_idx    = dump_idx_q;
    assign dump_eol    = dump_eol_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pc_halt_dump_monitor.sv
// Bench for pc_halt_dump_monitor: three parameterisations, a case table, random PC
// traces checked cycle by cycle against an event-timeline model, and an async-reset sequence.
module tb_pc_halt_dump_monitor;

    localparam int NI        = 3;
    localparam int NMAX      = 400;
    localparam int BASE      = 32;
    localparam logic [31:0] END_PC = 32'h90;
    localparam int MODE_SEQ  = 0;
    localparam int MODE_AT   = 1;
    localparam int MODE_NONE = 2;

    int p_d   [NI] = '{4, 4, 0};
    int p_w   [NI] = '{96, 96, 20};
    int p_wpl [NI] = '{16, 16, 16};
    int p_t   [NI] = '{100000, 50, 0};

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [31:0] pc_a    [NI];
    logic        pcv_a   [NI];
    logic [9:0]  raddr_a [NI];
    logic [31:0] rdata_a [NI];
    logic        halt_a  [NI];
    logic        valid_a [NI];
    logic [31:0] data_a  [NI];
    logic [9:0]  idx_a   [NI];
    logic        eol_a   [NI];
    logic        done_a  [NI];
    logic        to_a    [NI];
    logic [31:0] cc_a    [NI];
    logic [31:0] mem     [1024];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Synchronous-read data memory, one read port per instance.
    always @(posedge CLK) begin
        for (int i = 0; i < NI; i++) rdata_a[i] <= mem[raddr_a[i]];
    end

    pc_halt_dump_monitor u0 (
        .CLK(CLK), .CLR(CLR), .PC(pc_a[0]), .PC_VALID(pcv_a[0]),
        .dm_raddr(raddr_a[0]), .dm_rdata(rdata_a[0]), .halt_req(halt_a[0]),
        .dump_valid(valid_a[0]), .dump_data(data_a[0]), .dump_idx(idx_a[0]),
        .dump_eol(eol_a[0]), .done(done_a[0]), .timed_out(to_a[0]), .cycle_count(cc_a[0])
    );

    pc_halt_dump_monitor #(.TIMEOUT_CYCLES(50)) u1 (
        .CLK(CLK), .CLR(CLR), .PC(pc_a[1]), .PC_VALID(pcv_a[1]),
        .dm_raddr(raddr_a[1]), .dm_rdata(rdata_a[1]), .halt_req(halt_a[1]),
        .dump_valid(valid_a[1]), .dump_data(data_a[1]), .dump_idx(idx_a[1]),
        .dump_eol(eol_a[1]), .done(done_a[1]), .timed_out(to_a[1]), .cycle_count(cc_a[1])
    );

    pc_halt_dump_monitor #(.DUMP_WORDS(20), .WORDS_PER_LINE(16), .DRAIN_CYCLES(0),
                           .TIMEOUT_CYCLES(0)) u2 (
        .CLK(CLK), .CLR(CLR), .PC(pc_a[2]), .PC_VALID(pcv_a[2]),
        .dm_raddr(raddr_a[2]), .dm_rdata(rdata_a[2]), .halt_req(halt_a[2]),
        .dump_valid(valid_a[2]), .dump_data(data_a[2]), .dump_idx(idx_a[2]),
        .dump_eol(eol_a[2]), .done(done_a[2]), .timed_out(to_a[2]), .cycle_count(cc_a[2])
    );

    typedef struct {
        int inst;
        int mode;
        int m;
        int n_free;
        bit exp_to;
        int exp_cc;
    } vec_t;

    vec_t tab [8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic h, input logic v, input logic [31:0] d,
                                          input logic [9:0] i, input logic e, input logic dn,
                                          input logic t, input logic [31:0] cc);
        return {49'd0, h, v, d, i, e, dn, t, cc};
    endfunction

    function automatic logic [127:0] all_outs(input int inst);
        return {39'd0, raddr_a[inst], halt_a[inst], valid_a[inst], data_a[inst], idx_a[inst],
                eol_a[inst], done_a[inst], to_a[inst], cc_a[inst]};
    endfunction

    // One run from reset release: build a PC trace, derive the expected event timeline
    // from it, then compare every output on every cycle.
    task automatic run_case(input int inst, input int mode, input int m, input int n_free,
                            input bit do_reset, input string name,
                            output logic got_to, output logic [31:0] got_cc);
        logic [31:0] pcs [NMAX];
        logic        vs  [NMAX];
        int h, n, fv, k, d, w, wpl, t;
        bit to;
        logic e_halt, e_valid, e_eol, e_done, e_to;
        logic [31:0] e_cc, e_data;
        logic [9:0]  e_idx;
        logic [127:0] act;

        d = p_d[inst]; w = p_w[inst]; wpl = p_wpl[inst]; t = p_t[inst];
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        for (int c = 0; c < NMAX; c++) begin
            if (mode == MODE_SEQ) begin
                pcs[c] = 32'(4 * c);
                vs[c]  = 1'b1;
            end else begin
                pcs[c] = $urandom() & 32'hFFFF_FFFC;
                if (pcs[c] == END_PC) pcs[c] = 32'h94;
                vs[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) begin
                    pcs[c] = END_PC;
                    vs[c]  = (mode == MODE_AT && c > m) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if ((mode == MODE_AT && c == m - 1) || (mode == MODE_NONE && c == 10)) begin
                    pcs[c] = END_PC;
                    vs[c]  = 1'b0;
                end
                if (mode == MODE_AT && c == m) begin
                    pcs[c] = END_PC;
                    vs[c]  = 1'b1;
                end
            end
        end

        h = -1;
        to = 1'b0;
        for (int c = 0; c < NMAX; c++) begin
            if (vs[c] && pcs[c] == END_PC) begin h = c; break; end
            if (t != 0 && c == t - 1) begin h = c; to = 1'b1; break; end
        end
        n  = (h < 0) ? n_free : h + d + w + 6;
        if (n > NMAX) n = NMAX;
        fv = h + d + 2;

        for (int i = 0; i < NI; i++) begin pc_a[i] = 32'd0; pcv_a[i] = 1'b0; end
        if (do_reset) begin
            CLR = 1'b0;
            #1;
            check({name, " async reset"}, all_outs(inst), 128'd0);
            @(posedge CLK); #1;
            CLR = 1'b1;
        end

        got_to = 1'b0;
        got_cc = 32'd0;
        for (int c = 0; c < n; c++) begin
            pc_a[inst]  = pcs[c];
            pcv_a[inst] = vs[c];
            @(negedge CLK);
            e_halt  = (h >= 0) && (c > h);
            e_cc    = e_halt ? 32'(h + 1) : 32'(c);
            e_valid = (h >= 0) && (c >= fv) && (c < fv + w);
            e_done  = (h >= 0) && (c >= fv + w);
            e_to    = to && (c > h);
            k       = c - fv;
            if (e_valid) begin
                e_data = mem[BASE + k];
                e_idx  = 10'(BASE + k);
                e_eol  = (((k + 1) % wpl) == 0) || (k == w - 1);
                act = pack(halt_a[inst], valid_a[inst], data_a[inst], idx_a[inst],
                           eol_a[inst], done_a[inst], to_a[inst], cc_a[inst]);
            end else begin
                e_data = 32'd0;
                e_idx  = 10'd0;
                e_eol  = 1'b0;
                act = pack(halt_a[inst], valid_a[inst], 32'd0, 10'd0, 1'b0,
                           done_a[inst], to_a[inst], cc_a[inst]);
            end
            check($sformatf("%s c%0d", name, c), act,
                  pack(e_halt, e_valid, e_data, e_idx, e_eol, e_done, e_to, e_cc));
            got_to = to_a[inst];
            got_cc = cc_a[inst];
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        logic        g_to;
        logic [31:0] g_cc;
        bit          found;
        int          inst, mode, m;

        for (int i = 0; i < NI; i++) begin pc_a[i] = 32'd0; pcv_a[i] = 1'b0; end
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        repeat (2) @(posedge CLK);
        #1;

        tab[0] = '{0, MODE_SEQ,  0,   0,   1'b0, 37};
        tab[1] = '{1, MODE_NONE, 0,   0,   1'b1, 50};
        tab[2] = '{2, MODE_SEQ,  0,   0,   1'b0, 37};
        tab[3] = '{1, MODE_AT,   49,  0,   1'b0, 50};
        tab[4] = '{1, MODE_AT,   48,  0,   1'b0, 49};
        tab[5] = '{2, MODE_NONE, 0,   120, 1'b0, 119};
        tab[6] = '{0, MODE_AT,   0,   0,   1'b0, 1};
        tab[7] = '{1, MODE_AT,   50,  0,   1'b1, 50};

        for (int i = 0; i < 8; i++) begin
            run_case(tab[i].inst, tab[i].mode, tab[i].m, tab[i].n_free, 1'b1,
                     $sformatf("tab%0d", i), g_to, g_cc);
            check($sformatf("tab%0d timed_out", i), 128'(g_to), 128'(tab[i].exp_to));
            check($sformatf("tab%0d cycle_count", i), 128'(g_cc), 128'(tab[i].exp_cc));
        end

        // Reset pulse in the middle of the dump, then a fresh run without another reset.
        CLR = 1'b0;
        #1;
        @(posedge CLK); #1;
        CLR = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            pc_a[0]  = 32'(4 * c);
            pcv_a[0] = 1'b1;
            @(negedge CLK);
            if (valid_a[0] === 1'b1 && idx_a[0] === 10'd72) found = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        check("reach dump word 40", 128'(found), 128'd1);
        #2;
        CLR = 1'b0;
        #1;
        check("mid-dump async reset", all_outs(0), 128'd0);
        @(posedge CLK); #1;
        check("held in reset", all_outs(0), 128'd0);
        CLR = 1'b1;
        run_case(0, MODE_SEQ, 0, 0, 1'b0, "restart", g_to, g_cc);
        check("restart cycle_count", 128'(g_cc), 128'd37);

        for (int r = 0; r < 8; r++) begin
            inst = $urandom_range(0, NI - 1);
            mode = (inst == 1 && $urandom_range(0, 3) == 0) ? MODE_NONE : MODE_AT;
            m    = $urandom_range(0, 60);
            run_case(inst, mode, m, 0, 1'b1, $sformatf("rnd%0d", r), g_to, g_cc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
